// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR enter a byte FIFO that
// drains onto txd, and a combinational status word is offered to the load path.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] TX_ADDR      = 32'h0000_F000,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_F004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;

    logic            tx_sel;
    logic            stat_sel;
    logic            full;
    logic            empty;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            baud_last;
    logic            tx_busy;
    logic [7:0]      count8;
    logic            unused_wdata;

    assign tx_sel    = (addr == TX_ADDR);
    assign stat_sel  = (addr == STAT_ADDR);
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign push_req  = we && tx_sel;
    assign push      = push_req && !full;
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign tx_busy   = (state != IDLE);

    // The FSM takes the head byte either from IDLE or at the last STOP cycle,
    // which is what makes consecutive frames run without an idle gap.
    assign pop = !empty && ((state == IDLE) || (state == STOP && baud_last));

    assign hit          = tx_sel || stat_sel;
    assign count8       = 8'(count);
    assign rdata        = {16'h0000, count8, 4'h0, overflow, tx_busy, empty, full};
    assign unused_wdata = ^wdata[31:8];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    // Full is judged before the edge, so a push meeting a pop on a full FIFO is still dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (we && stat_sel) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            txd       <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        txd       <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        txd      <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            txd       <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg <= mem[rd_ptr];
                            txd       <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register/status vector table, serial-frame scoreboard,
// and hand-written sequences for overflow, back-to-back frames and reset abort.
module tb_mmio_uart_tx;

    localparam int          CPB = 4;
    localparam logic [31:0] TXA = 32'h0000_F000;
    localparam logic [31:0] STA = 32'h0000_F004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        hit;
    logic [31:0] rdata;
    logic        txd;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rdata;
        logic        exp_txd;
    } vec_t;

    vec_t vecs[8];

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (16),
        .TX_ADDR     (TXA),
        .STAT_ADDR   (STA)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .hit  (hit),
        .rdata(rdata),
        .txd  (txd)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        apply_stimulus(1'b1, a, d);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check_output(name, exp_q.size(), 0);
    endtask

    task automatic mon_wait(input int n, inout bit ab);
        repeat (n) begin
            tick();
            if (!rst) ab = 1'b1;
        end
    endtask

    // Frame decoder: samples each bit at its centre and scores the byte against the queue.
    initial begin
        logic [7:0] byte_v;
        logic [7:0] e;
        bit ab;
        forever begin
            tick();
            if (rst === 1'b1 && txd === 1'b0) begin
                ab = 1'b0;
                byte_v = '0;
                mon_wait(2, ab);
                if (!ab) check_output("start_bit", {31'b0, txd}, 32'h0);
                for (int b = 0; b < 8 && !ab; b++) begin
                    mon_wait(4, ab);
                    byte_v[b] = txd;
                end
                if (!ab) mon_wait(4, ab);
                if (!ab) begin
                    check_output("stop_bit", {31'b0, txd}, 32'h1);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_frame: got %h, expected no frame", byte_v);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("frame_byte", {24'h0, byte_v}, {24'h0, e});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy_cnt;
        logic [7:0] d;
        logic exp_bit;
        bit saw_low;

        vecs[0] = '{1'b0, STA,          32'h0000_0000, 1'b1, 32'h0000_0002, 1'b1};
        vecs[1] = '{1'b0, TXA,          32'h0000_0041, 1'b1, 32'h0000_0002, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_F008, 32'h0000_00AB, 1'b0, 32'h0000_0002, 1'b1};
        vecs[3] = '{1'b0, STA,          32'h0000_0000, 1'b1, 32'h0000_0002, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_F005, 32'h0000_0000, 1'b0, 32'h0000_0002, 1'b1};
        vecs[5] = '{1'b0, 32'h1000_F000, 32'h0000_0000, 1'b0, 32'h0000_0002, 1'b1};
        vecs[6] = '{1'b1, STA,          32'hFFFF_FFFF, 1'b1, 32'h0000_0002, 1'b1};
        vecs[7] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0002, 1'b1};

        #2 rst = 1'b0;
        #1;
        check_output("reset_txd", {31'b0, txd}, 32'h1);
        check_output("reset_status", rdata, 32'h0000_0002);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            #1;
            check_output($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
            check_output($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d_txd", i), {31'b0, txd}, {31'b0, vecs[i].exp_txd});
            tick();
        end
        apply_stimulus(1'b0, 32'h0, 32'h0);
        repeat (3) tick();

        d = 8'h55;
        exp_q.push_back(d);
        store(TXA, {24'h0, d});
        check_output("single_pushed_status", rdata, 32'h0000_0100);
        busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rdata[2]) busy_cnt++;
            if (i < 44) begin
                if (i < 4) exp_bit = 1'b0;
                else if (i < 36) exp_bit = d[(i - 4) / 4];
                else exp_bit = 1'b1;
                check_output($sformatf("frame55_cycle%0d", i), {31'b0, txd}, {31'b0, exp_bit});
            end
        end
        check_output("frame55_busy_cycles", busy_cnt, 40);
        wait_drain("drain_single");

        for (int k = 0; k < 18; k++) begin
            apply_stimulus(1'b1, TXA, 32'h10 + k);
            if (k < 17) exp_q.push_back(8'(8'h10 + k));
            tick();
        end
        apply_stimulus(1'b0, 32'h0, 32'h0);
        check_output("overflow_status", rdata, 32'h0000_100D);
        store(STA, 32'hFFFF_FFFF);
        check_output("overflow_cleared", rdata, 32'h0000_1005);
        repeat (22) tick();
        check_output("full_before_pop", rdata, 32'h0000_1005);
        store(TXA, 32'h0000_00EE);
        check_output("full_push_with_pop", rdata, 32'h0000_0F0C);
        store(STA, 32'h0);
        check_output("overflow_cleared2", rdata, 32'h0000_0F04);
        wait_drain("drain_burst");
        repeat (4) tick();
        check_output("idle_after_burst", rdata, 32'h0000_0002);

        exp_q.push_back(8'hA5);
        store(TXA, 32'h0000_00A5);
        exp_q.push_back(8'h3C);
        store(TXA, 32'h0000_003C);
        check_output("push_pop_same_cycle", rdata, 32'h0000_0104);
        busy_cnt = 0;
        while (rdata[2] && busy_cnt < 200) begin
            busy_cnt++;
            tick();
        end
        check_output("back_to_back_busy", busy_cnt, 80);
        wait_drain("drain_pair");
        repeat (4) tick();

        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b1, TXA, 32'h81 + k);
            exp_q.push_back(8'(8'h81 + k));
            tick();
        end
        apply_stimulus(1'b0, 32'h0, 32'h0);
        check_output("queued_five", rdata, 32'h0000_0504);
        repeat (13) tick();
        #2 rst = 1'b0;
        #1;
        check_output("abort_txd", {31'b0, txd}, 32'h1);
        check_output("abort_status", rdata, 32'h0000_0002);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (txd !== 1'b1 || rdata[2] !== 1'b0) saw_low = 1'b1;
        end
        check_output("no_frame_after_reset", {31'b0, saw_low}, 32'h0);
        check_output("idle_after_reset", rdata, 32'h0000_0002);
        check_output("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
